// File: rtl/cpu_fetch_q.sv
// Instruction-fetch stage: redirectable PC, pipelined in-order memory interface and a
// DEPTH-entry {instr, pc} queue toward decode, with credit-based request throttling.
module cpu_fetch_q #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);
    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = PW + 1;
    localparam logic [ADDR_W-1:0] INC     = ADDR_W'(PC_INC);
    localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  rsp_pc;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      drop;
    logic [CW-1:0]      count;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];

    logic [CW:0] credit;
    logic        accept;
    logic        push;
    logic        pop;

    // Queued entries plus outstanding requests never exceed DEPTH, so a response always has a slot.
    assign credit    = {1'b0, count} + {1'b0, inflight};
    assign imem_req  = rst_n & ~redirect_valid & (credit < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req & imem_ready;

    assign out_valid = (count != '0);
    assign out_instr = q_instr[rd_ptr];
    assign out_pc    = q_pc[rd_ptr];

    assign push = imem_rvalid & (drop == '0) & ~redirect_valid;
    assign pop  = out_valid & out_ready & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            inflight <= inflight + CW'(accept) - CW'(imem_rvalid);
            if (redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the old stream.
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop     <= inflight - CW'(imem_rvalid);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + INC;
                if (imem_rvalid && drop != '0)
                    drop <= drop - CW'(1);
                if (push) begin
                    q_instr[wr_ptr] <= imem_rdata;
                    q_pc[wr_ptr]    <= rsp_pc;
                    wr_ptr          <= wr_ptr + PW'(1);
                    rsp_pc          <= rsp_pc + INC;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifndef SYNTHESIS
    rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (inflight != '0));
`endif

endmodule

// File: tb/tb_cpu_fetch_q.sv
// Bench for cpu_fetch_q: directed cycle table, then an in-order variable-latency memory
// with epoch-tagged requests checked against a queue-level model of the fetch stream.
module tb_cpu_fetch_q;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready = 1'b0;

    cpu_fetch_q #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_INC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory holds requests tagged with the stream epoch they belong to;
    // decode must see exactly the kept responses, in request order, with their request address.
    typedef struct { logic [15:0] addr; int epoch; int due; } pend_t;
    typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
    pend_t       pend[$];
    ent_t        mq[$];
    logic [15:0] m_fetch = '0;
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0000);
        chk("rst_out_pc", 32'(out_pc), 32'h0000);
        chk("rst_out_instr", 32'(out_instr), 32'h0000);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        mq.delete(); pend.delete();
        m_fetch = 16'h0000; epoch++; last_due = cyc;
    endtask

    // One clock cycle; entered 1ns after a rising edge and leaves 1ns after the next.
    task automatic run_cycle(input bit redir, input logic [15:0] rpc, input int lat_min,
                             input int lat_max, input int rdy_pct, input int ordy_pct);
        bit    exp_req;
        pend_t p;
        int    d;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ready     = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < ordy_pct);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        #4;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
            chk("out_instr", 32'(out_instr), 32'(mq[0].instr));
        end
        exp_req = !redir && (mq.size() + pend.size() < DEPTH);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("imem_addr", 32'(imem_addr), 32'(m_fetch));

        if (imem_rvalid) p = pend.pop_front();
        if (redir) begin
            mq.delete();
            epoch++;
            m_fetch = rpc;
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (imem_rvalid && p.epoch == epoch) mq.push_back('{pc: p.addr, instr: mem_data(p.addr)});
        end
        if (exp_req && imem_ready) begin
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d <= last_due) d = last_due + 1;
            pend.push_back('{addr: m_fetch, epoch: epoch, due: d});
            last_due = d;
            m_fetch  = m_fetch + 16'd2;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    typedef struct {
        bit redir; logic [15:0] rpc; bit rdy; bit rv; logic [15:0] raddr; bit ordy;
        bit ereq; logic [15:0] eaddr; bit evalid; logic [15:0] epc;
    } vec_t;
    vec_t tbl[15];

    initial begin
        // L=1 memory: fill to DEPTH with decode stalled, drain, then redirect colliding
        // with a response and a pop.
        tbl[0]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000};
        tbl[1]  = '{0, 16'h0000, 1, 1, 16'h0000, 0, 1, 16'h0002, 0, 16'h0000};
        tbl[2]  = '{0, 16'h0000, 1, 1, 16'h0002, 0, 1, 16'h0004, 1, 16'h0000};
        tbl[3]  = '{0, 16'h0000, 1, 1, 16'h0004, 0, 1, 16'h0006, 1, 16'h0000};
        tbl[4]  = '{0, 16'h0000, 1, 1, 16'h0006, 0, 0, 16'h0008, 1, 16'h0000};
        tbl[5]  = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0000};
        tbl[6]  = '{0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0008, 1, 16'h0000};
        tbl[7]  = '{0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'h0002};
        tbl[8]  = '{0, 16'h0000, 1, 1, 16'h0008, 1, 1, 16'h000A, 1, 16'h0004};
        tbl[9]  = '{0, 16'h0000, 1, 1, 16'h000A, 1, 1, 16'h000C, 1, 16'h0006};
        tbl[10] = '{0, 16'h0000, 1, 1, 16'h000C, 1, 1, 16'h000E, 1, 16'h0008};
        tbl[11] = '{1, 16'h0100, 1, 1, 16'h000E, 1, 0, 16'h0010, 1, 16'h000A};
        tbl[12] = '{0, 16'h0000, 1, 0, 16'h0000, 1, 1, 16'h0100, 0, 16'h0000};
        tbl[13] = '{0, 16'h0000, 1, 1, 16'h0100, 1, 1, 16'h0102, 0, 16'h0000};
        tbl[14] = '{0, 16'h0000, 1, 1, 16'h0102, 1, 1, 16'h0104, 1, 16'h0100};

        #1;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            imem_ready     = tbl[i].rdy;
            imem_rvalid    = tbl[i].rv;
            imem_rdata     = tbl[i].rv ? mem_data(tbl[i].raddr) : 16'h0000;
            out_ready      = tbl[i].ordy;
            #4;
            chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].ereq));
            chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].eaddr));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].evalid));
            if (tbl[i].evalid) begin
                chk($sformatf("tbl%0d_pc", i), 32'(out_pc), 32'(tbl[i].epc));
                chk($sformatf("tbl%0d_instr", i), 32'(out_instr), 32'(mem_data(tbl[i].epc)));
            end
            @(posedge clk);
            #1;
        end

        do_reset();
        for (int i = 0; i < 20; i++) run_cycle(0, 16'h0, 1, 1, 100, 100);

        // Fixed L=3 pipeline, then redirect with responses still in flight.
        for (int i = 0; i < 8; i++) run_cycle(0, 16'h0, 3, 3, 100, 100);
        run_cycle(1, 16'h0100, 3, 3, 100, 100);
        for (int i = 0; i < 4; i++) run_cycle(0, 16'h0, 3, 3, 100, 100);
        chk("redir_first_valid", 32'(out_valid), 32'd1);
        chk("redir_first_pc", 32'(out_pc), 32'h0100);
        for (int i = 0; i < 6; i++) run_cycle(0, 16'h0, 3, 3, 100, 100);

        for (int i = 0; i < 800; i++) begin
            bit r;
            r = ($urandom_range(99) < 5);
            run_cycle(r, 16'($urandom) & 16'hFFFE, 1, 4, 60, 60);
        end

        run_cycle(1, 16'hFFFE, 1, 3, 50, 70);
        for (int i = 0; i < 40; i++) run_cycle(0, 16'h0, 1, 3, 50, 70);

        // Fill the queue with decode stalled, then reset mid-operation.
        for (int i = 0; i < 12; i++) run_cycle(0, 16'h0, 1, 1, 100, 0);
        chk("full_before_reset", 32'(out_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 12; i++) run_cycle(0, 16'h0, 1, 2, 100, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
